// File: rtl/fio_init_sequencer_if.sv
// Host word stream and MEM dump stream between the host and fio_init_sequencer.
// The sequencer connects through the slave modport and the host side uses master.
interface fio_init_sequencer_if;
    logic         host_valid;
    logic         host_ready;
    logic [31:0]  host_data;
    logic         dump_valid;
    logic         dump_ready;
    logic [255:0] dump_data;

    modport master (
        output host_valid, host_data, dump_ready,
        input  host_ready, dump_valid, dump_data
    );

    modport slave (
        input  host_valid, host_data, dump_ready,
        output host_ready, dump_valid, dump_data
    );
endinterface

// File: rtl/fio_init_sequencer.sv
// Loads TM table, ICache, MEM lines and latency table from one host stream, runs the TM,
// then optionally dumps MEM back to the host. Define FIO_DUMP_EN to build the DUMP state.
module fio_init_sequencer #(
    parameter int TM_DEPTH    = 8,
    parameter int IC_DEPTH    = 4096,
    parameter int MEM_DEPTH   = 256,
    parameter int SHMEM_DEPTH = 256,
    parameter int LAT_DEPTH   = 256,
    parameter int RD_LAT      = 2,
    localparam int AW = $clog2(MEM_DEPTH + SHMEM_DEPTH),
    localparam int CW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    fio_init_sequencer_if.slave   bus,
    output logic [3:0]            phase,
    output logic                  done,
    output logic                  Write_Enable_FIO_TM,
    output logic [28:0]           Write_Data_FIO_TM,
    output logic                  start_FIO_TM,
    output logic                  clear_FIO_TM,
    input  logic                  finished_TM_FIO,
    output logic                  FileIO_Wen_ICache,
    output logic [11:0]           FileIO_Addr_ICache,
    output logic [31:0]           FileIO_Din_ICache,
    output logic                  FIO_MEMWRITE,
    output logic [AW-1:0]         FIO_ADDR,
    output logic [255:0]          FIO_WRITE_DATA,
    input  logic [255:0]          FIO_READ_DATA,
    output logic                  FIO_CACHE_LAT_WRITE,
    output logic [4:0]            FIO_CACHE_LAT_VALUE,
    output logic [CW-1:0]         FIO_CACHE_MEM_ADDR
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LD_TM  = 4'd1,
        LD_IC  = 4'd2,
        LD_MEM = 4'd3,
        LD_LAT = 4'd4,
        RUN    = 4'd5,
        WAIT   = 4'd6,
        DUMP   = 4'd7,
        DONE   = 4'd8
    } state_t;

    localparam int MAX_AB = (TM_DEPTH > IC_DEPTH) ? TM_DEPTH : IC_DEPTH;
    localparam int MAX_CD = (MEM_DEPTH > LAT_DEPTH) ? MEM_DEPTH : LAT_DEPTH;
    localparam int MAXD   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int NW     = $clog2(MAXD + 1);
    localparam int LW     = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    localparam logic [NW-1:0] TM_LAST  = NW'(TM_DEPTH - 1);
    localparam logic [NW-1:0] IC_LAST  = NW'(IC_DEPTH - 1);
    localparam logic [NW-1:0] MEM_LAST = NW'(MEM_DEPTH - 1);
    localparam logic [NW-1:0] LAT_LAST = NW'(LAT_DEPTH - 1);
    localparam logic [LW-1:0] RD_WAIT  = LW'(RD_LAT);

    state_t         state_q, state_d;
    logic [NW-1:0]  idx_q, idx_d;
    logic [2:0]     word_q, word_d;
    logic [255:0]   pack_q, pack_d;
    logic [LW-1:0]  wait_q, wait_d;
    logic           tm_we_q, tm_we_d;
    logic [28:0]    tm_data_q, tm_data_d;
    logic           clear_q, clear_d;
    logic           start_q, start_d;
    logic           ic_wen_q, ic_wen_d;
    logic [11:0]    ic_addr_q, ic_addr_d;
    logic [31:0]    ic_din_q, ic_din_d;
    logic           memwrite_q, memwrite_d;
    logic [AW-1:0]  fio_addr_q, fio_addr_d;
    logic [255:0]   fio_wdata_q, fio_wdata_d;
    logic           lat_we_q, lat_we_d;
    logic [4:0]     lat_val_q, lat_val_d;
    logic [CW-1:0]  lat_addr_q, lat_addr_d;
    logic           dump_valid_q, dump_valid_d;
    logic [255:0]   dump_data_q, dump_data_d;
    logic           beat;

    assign bus.host_ready = (state_q == LD_TM) || (state_q == LD_IC) ||
                            (state_q == LD_MEM) || (state_q == LD_LAT);
    assign beat = bus.host_valid && bus.host_ready;

    // Every target write is registered: the beat computes strobe/addr/data for the next cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        pack_d       = pack_q;
        wait_d       = wait_q;
        tm_we_d      = 1'b0;
        tm_data_d    = tm_data_q;
        clear_d      = 1'b0;
        start_d      = start_q;
        ic_wen_d     = 1'b0;
        ic_addr_d    = ic_addr_q;
        ic_din_d     = ic_din_q;
        memwrite_d   = 1'b0;
        fio_addr_d   = fio_addr_q;
        fio_wdata_d  = fio_wdata_q;
        lat_we_d     = 1'b0;
        lat_val_d    = lat_val_q;
        lat_addr_d   = lat_addr_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    clear_d = 1'b1;
                    idx_d   = '0;
                    state_d = LD_TM;
                end
            end
            LD_TM: begin
                if (beat) begin
                    tm_we_d   = 1'b1;
                    tm_data_d = bus.host_data[28:0];
                    if (idx_q == TM_LAST) begin
                        idx_d   = '0;
                        state_d = LD_IC;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LD_IC: begin
                if (beat) begin
                    ic_wen_d  = 1'b1;
                    ic_addr_d = 12'(idx_q);
                    ic_din_d  = bus.host_data;
                    if (idx_q == IC_LAST) begin
                        idx_d   = '0;
                        word_d  = '0;
                        state_d = LD_MEM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LD_MEM: begin
                if (beat) begin
                    pack_d[{word_q, 5'd0} +: 32] = bus.host_data;
                    if (word_q == 3'd7) begin
                        memwrite_d  = 1'b1;
                        fio_addr_d  = AW'(idx_q);
                        fio_wdata_d = {bus.host_data, pack_q[223:0]};
                        word_d      = '0;
                        if (idx_q == MEM_LAST) begin
                            idx_d   = '0;
                            state_d = LD_LAT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            LD_LAT: begin
                if (beat) begin
                    lat_we_d   = 1'b1;
                    lat_val_d  = bus.host_data[4:0];
                    lat_addr_d = CW'(idx_q);
                    if (idx_q == LAT_LAST) begin
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (finished_TM_FIO) begin
                    start_d = 1'b0;
`ifdef FIO_DUMP_EN
                    idx_d      = '0;
                    wait_d     = '0;
                    fio_addr_d = '0;
                    state_d    = DUMP;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef FIO_DUMP_EN
            // Address is held for RD_LAT cycles, then the read word is captured and offered.
            DUMP: begin
                if (!dump_valid_q) begin
                    if (wait_q == RD_WAIT) begin
                        dump_valid_d = 1'b1;
                        dump_data_d  = FIO_READ_DATA;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else if (bus.dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (idx_q == MEM_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        fio_addr_d = AW'(idx_q + 1'b1);
                        wait_d     = '0;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            word_q       <= '0;
            pack_q       <= '0;
            wait_q       <= '0;
            tm_we_q      <= 1'b0;
            tm_data_q    <= '0;
            clear_q      <= 1'b0;
            start_q      <= 1'b0;
            ic_wen_q     <= 1'b0;
            ic_addr_q    <= '0;
            ic_din_q     <= '0;
            memwrite_q   <= 1'b0;
            fio_addr_q   <= '0;
            fio_wdata_q  <= '0;
            lat_we_q     <= 1'b0;
            lat_val_q    <= '0;
            lat_addr_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            pack_q       <= pack_d;
            wait_q       <= wait_d;
            tm_we_q      <= tm_we_d;
            tm_data_q    <= tm_data_d;
            clear_q      <= clear_d;
            start_q      <= start_d;
            ic_wen_q     <= ic_wen_d;
            ic_addr_q    <= ic_addr_d;
            ic_din_q     <= ic_din_d;
            memwrite_q   <= memwrite_d;
            fio_addr_q   <= fio_addr_d;
            fio_wdata_q  <= fio_wdata_d;
            lat_we_q     <= lat_we_d;
            lat_val_q    <= lat_val_d;
            lat_addr_q   <= lat_addr_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
        end
    end

`ifdef FIO_DUMP_EN
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_data  = dump_data_q;
`else
    logic unused_dump;
    assign unused_dump    = ^{FIO_READ_DATA, bus.dump_ready, dump_valid_q, dump_data_q};
    assign bus.dump_valid = 1'b0;
    assign bus.dump_data  = '0;
`endif

    assign phase               = state_q;
    assign done                = (state_q == DONE);
    assign Write_Enable_FIO_TM = tm_we_q;
    assign Write_Data_FIO_TM   = tm_data_q;
    assign start_FIO_TM        = start_q;
    assign clear_FIO_TM        = clear_q;
    assign FileIO_Wen_ICache   = ic_wen_q;
    assign FileIO_Addr_ICache  = ic_addr_q;
    assign FileIO_Din_ICache   = ic_din_q;
    assign FIO_MEMWRITE        = memwrite_q;
    assign FIO_ADDR            = fio_addr_q;
    assign FIO_WRITE_DATA      = fio_wdata_q;
    assign FIO_CACHE_LAT_WRITE = lat_we_q;
    assign FIO_CACHE_LAT_VALUE = lat_val_q;
    assign FIO_CACHE_MEM_ADDR  = lat_addr_q;

endmodule

// File: tb/tb_fio_init_sequencer.sv
// Bench for fio_init_sequencer: directed load/run/dump, reset abort, then a randomized load
// whose target writes and dump lines are checked against a word-stream reference model.
module tb_fio_init_sequencer;

    localparam int NTM  = 8;
    localparam int NIC  = 16;
    localparam int NMEM = 4;
    localparam int NLAT = 4;
    localparam int NWORDS = NTM + NIC + NMEM * 8 + NLAT;

    typedef struct {
        logic [31:0] word;
        logic [31:0] expv;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [3:0]   phase;
    logic         done;
    logic         Write_Enable_FIO_TM;
    logic [28:0]  Write_Data_FIO_TM;
    logic         start_FIO_TM;
    logic         clear_FIO_TM;
    logic         finished_TM_FIO;
    logic         FileIO_Wen_ICache;
    logic [11:0]  FileIO_Addr_ICache;
    logic [31:0]  FileIO_Din_ICache;
    logic         FIO_MEMWRITE;
    logic [8:0]   FIO_ADDR;
    logic [255:0] FIO_WRITE_DATA;
    logic [255:0] FIO_READ_DATA;
    logic         FIO_CACHE_LAT_WRITE;
    logic [4:0]   FIO_CACHE_LAT_VALUE;
    logic [1:0]   FIO_CACHE_MEM_ADDR;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    fio_init_sequencer_if bus ();

    fio_init_sequencer #(
        .TM_DEPTH(NTM), .IC_DEPTH(NIC), .MEM_DEPTH(NMEM), .LAT_DEPTH(NLAT), .RD_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .bus(bus), .phase(phase), .done(done),
        .Write_Enable_FIO_TM(Write_Enable_FIO_TM), .Write_Data_FIO_TM(Write_Data_FIO_TM),
        .start_FIO_TM(start_FIO_TM), .clear_FIO_TM(clear_FIO_TM),
        .finished_TM_FIO(finished_TM_FIO),
        .FileIO_Wen_ICache(FileIO_Wen_ICache), .FileIO_Addr_ICache(FileIO_Addr_ICache),
        .FileIO_Din_ICache(FileIO_Din_ICache),
        .FIO_MEMWRITE(FIO_MEMWRITE), .FIO_ADDR(FIO_ADDR), .FIO_WRITE_DATA(FIO_WRITE_DATA),
        .FIO_READ_DATA(FIO_READ_DATA),
        .FIO_CACHE_LAT_WRITE(FIO_CACHE_LAT_WRITE), .FIO_CACHE_LAT_VALUE(FIO_CACHE_LAT_VALUE),
        .FIO_CACHE_MEM_ADDR(FIO_CACHE_MEM_ADDR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural MEM: writes land on the strobe, reads appear two cycles after the address.
    logic [255:0] mem_arr [NMEM];
    logic [255:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (FIO_MEMWRITE && FIO_ADDR < 9'd4) mem_arr[FIO_ADDR[1:0]] <= FIO_WRITE_DATA;
        rd_p1 <= (FIO_ADDR < 9'd4) ? mem_arr[FIO_ADDR[1:0]] : '0;
        rd_p2 <= rd_p1;
    end
    assign FIO_READ_DATA = rd_p2;

    logic [28:0]  tm_log[$];
    int           tm_cyc[$];
    logic [11:0]  ic_addr_log[$];
    logic [31:0]  ic_data_log[$];
    logic [8:0]   mem_addr_log[$];
    logic [255:0] mem_data_log[$];
    logic [1:0]   lat_addr_log[$];
    logic [4:0]   lat_val_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (Write_Enable_FIO_TM) begin
                tm_log.push_back(Write_Data_FIO_TM);
                tm_cyc.push_back(cycle);
            end
            if (FileIO_Wen_ICache) begin
                ic_addr_log.push_back(FileIO_Addr_ICache);
                ic_data_log.push_back(FileIO_Din_ICache);
            end
            if (FIO_MEMWRITE) begin
                mem_addr_log.push_back(FIO_ADDR);
                mem_data_log.push_back(FIO_WRITE_DATA);
            end
            if (FIO_CACHE_LAT_WRITE) begin
                lat_addr_log.push_back(FIO_CACHE_MEM_ADDR);
                lat_val_log.push_back(FIO_CACHE_LAT_VALUE);
            end
        end
    end

    logic [31:0]  wds [NWORDS];
    logic [255:0] exp_lines [NMEM];
    vec_t         tm_tab [NTM];
    vec_t         lat_tab [NLAT];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] w, input bit gap);
        int n;
        if (gap) begin
            bus.host_valid = 1'b0;
            tick();
        end
        bus.host_valid = 1'b1;
        bus.host_data  = w;
        n = 0;
        while (!bus.host_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.host_ready) check_output("host_ready_timeout", bus.host_ready, 1);
        tick();
        bus.host_valid = 1'b0;
    endtask

    task automatic clear_logs();
        tm_log.delete(); tm_cyc.delete();
        ic_addr_log.delete(); ic_data_log.delete();
        mem_addr_log.delete(); mem_data_log.delete();
        lat_addr_log.delete(); lat_val_log.delete();
    endtask

    // Reference model: MEM line j is host words 24+8j .. 24+8j+7, lowest word in the low bits.
    task automatic build_model();
        for (int j = 0; j < NMEM; j++)
            for (int k = 0; k < 8; k++)
                exp_lines[j][32*k +: 32] = wds[NTM + NIC + 8*j + k];
    endtask

    task automatic compare_logs(input bit check_cycles);
        check_output("tm_count", tm_log.size(), NTM);
        check_output("ic_count", ic_data_log.size(), NIC);
        check_output("mem_count", mem_data_log.size(), NMEM);
        check_output("lat_count", lat_val_log.size(), NLAT);
        for (int i = 0; i < NTM; i++) if (i < tm_log.size()) begin
            check_output($sformatf("tm_data[%0d]", i), tm_log[i], wds[i][28:0]);
            if (check_cycles) check_output($sformatf("tm_gap[%0d]", i), tm_cyc[i] - tm_cyc[0], i);
        end
        for (int i = 0; i < NIC; i++) if (i < ic_data_log.size()) begin
            check_output($sformatf("ic_addr[%0d]", i), ic_addr_log[i], i);
            check_output($sformatf("ic_data[%0d]", i), ic_data_log[i], wds[NTM + i]);
        end
        for (int j = 0; j < NMEM; j++) if (j < mem_data_log.size()) begin
            check_output($sformatf("mem_addr[%0d]", j), mem_addr_log[j], j);
            check_output($sformatf("mem_line[%0d]", j), mem_data_log[j], exp_lines[j]);
        end
        for (int i = 0; i < NLAT; i++) if (i < lat_val_log.size()) begin
            check_output($sformatf("lat_addr[%0d]", i), lat_addr_log[i], i);
            check_output($sformatf("lat_val[%0d]", i), lat_val_log[i], wds[NTM + NIC + 8*NMEM + i][4:0]);
        end
    endtask

    task automatic collect_dump(input int first_stall, input bit rnd);
        int n;
        int stall;
        for (int j = 0; j < NMEM; j++) begin
            n = 0;
            while (!bus.dump_valid && n < 20) begin
                tick();
                n++;
            end
            check_output($sformatf("dump_valid[%0d]", j), bus.dump_valid, 1);
            if (!bus.dump_valid) return;
            check_output($sformatf("dump_line[%0d]", j), bus.dump_data, exp_lines[j]);
            stall = (j == 0) ? first_stall : (rnd ? int'($urandom_range(0, 3)) : 0);
            for (int s = 0; s < stall; s++) begin
                tick();
                check_output("dump_hold_valid", bus.dump_valid, 1);
                check_output("dump_hold_data", bus.dump_data, exp_lines[j]);
            end
            bus.dump_ready = 1'b1;
            tick();
            bus.dump_ready = 1'b0;
        end
    endtask

    task automatic finish_run(input int first_stall, input bit rnd);
`ifdef FIO_DUMP_EN
        check_output("phase_dump", phase, 7);
        check_output("start_drop", start_FIO_TM, 0);
        collect_dump(first_stall, rnd);
`else
        check_output("dump_valid_tied", bus.dump_valid, 0);
        check_output("dump_data_tied", bus.dump_data, 0);
        check_output("start_drop", start_FIO_TM, 0);
`endif
        check_output("phase_done", phase, 8);
        check_output("done", done, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NTM; i++) tm_tab[i] = '{32'(i + 1), 32'(i + 1)};
        lat_tab[0] = '{32'h3F, 32'h1F};
        lat_tab[1] = '{32'h21, 32'h01};
        lat_tab[2] = '{32'h05, 32'h05};
        lat_tab[3] = '{32'h00, 32'h00};
        for (int i = 0; i < NTM; i++) wds[i] = tm_tab[i].word;
        for (int i = 0; i < NIC; i++) wds[NTM + i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 8*NMEM; i++) wds[NTM + NIC + i] = 32'(i);
        for (int i = 0; i < NLAT; i++) wds[NTM + NIC + 8*NMEM + i] = lat_tab[i].word;
        build_model();

        rst = 1'b1; go = 1'b0; finished_TM_FIO = 1'b0;
        bus.host_valid = 1'b0; bus.host_data = '0; bus.dump_ready = 1'b0;
        tick(); tick();
        check_output("rst_phase", phase, 0);
        check_output("rst_done", done, 0);
        check_output("rst_host_ready", bus.host_ready, 0);
        check_output("rst_strobes", {Write_Enable_FIO_TM, FileIO_Wen_ICache, FIO_MEMWRITE, FIO_CACHE_LAT_WRITE}, 0);
        check_output("rst_ctrl", {clear_FIO_TM, start_FIO_TM, bus.dump_valid}, 0);
        check_output("rst_addr", FIO_ADDR, 0);
        rst = 1'b0;
        tick();
        check_output("idle_hold", phase, 0);

        clear_logs();
        go = 1'b1; tick(); go = 1'b0;
        check_output("clear_pulse", clear_FIO_TM, 1);
        check_output("phase_tm", phase, 1);
        for (int i = 0; i < NTM; i++) begin
            apply_stimulus(tm_tab[i].word, 1'b0);
            if (i == 0) check_output("clear_once", clear_FIO_TM, 0);
            check_output($sformatf("tm_we[%0d]", i), Write_Enable_FIO_TM, 1);
            check_output($sformatf("tm_vec[%0d]", i), Write_Data_FIO_TM, tm_tab[i].expv);
        end
        check_output("phase_ic", phase, 2);
        for (int i = 0; i < NIC; i++) begin
            apply_stimulus(wds[NTM + i], 1'b1);
            check_output($sformatf("ic_wen[%0d]", i), FileIO_Wen_ICache, 1);
            check_output($sformatf("ic_live_addr[%0d]", i), FileIO_Addr_ICache, i);
        end
        check_output("phase_mem", phase, 3);
        for (int i = 0; i < 8*NMEM; i++) apply_stimulus(wds[NTM + NIC + i], 1'b0);
        check_output("phase_lat", phase, 4);
        check_output("last_memwrite", FIO_MEMWRITE, 1);
        check_output("last_mem_addr", FIO_ADDR, 3);
        for (int i = 0; i < NLAT; i++) begin
            apply_stimulus(lat_tab[i].word, 1'b0);
            check_output($sformatf("lat_we[%0d]", i), FIO_CACHE_LAT_WRITE, 1);
            check_output($sformatf("lat_vec[%0d]", i), FIO_CACHE_LAT_VALUE, lat_tab[i].expv);
        end
        check_output("phase_run", phase, 5);
        tick();
        check_output("phase_wait", phase, 6);
        check_output("start_high", start_FIO_TM, 1);
        check_output("wait_not_ready", bus.host_ready, 0);
        tick();
        compare_logs(1'b1);
        check_output("line0_literal", mem_data_log.size() > 0 ? mem_data_log[0] : '0,
                     {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0});
        go = 1'b1; tick(); go = 1'b0;
        check_output("go_ignored_phase", phase, 6);
        check_output("go_ignored_clear", clear_FIO_TM, 0);
        check_output("start_held", start_FIO_TM, 1);
        finished_TM_FIO = 1'b1; tick(); finished_TM_FIO = 1'b0;
        finish_run(3, 1'b0);

        go = 1'b1; tick(); go = 1'b0;
        check_output("rerun_clear", clear_FIO_TM, 1);
        for (int i = 0; i < NTM + NIC + 5; i++) apply_stimulus($urandom, 1'b0);
        check_output("abort_phase_mem", phase, 3);
        rst = 1'b1; tick();
        check_output("abort_phase", phase, 0);
        check_output("abort_strobes", {Write_Enable_FIO_TM, FileIO_Wen_ICache, FIO_MEMWRITE, FIO_CACHE_LAT_WRITE}, 0);
        check_output("abort_ctrl", {clear_FIO_TM, start_FIO_TM, bus.host_ready}, 0);
        rst = 1'b0; tick();
        check_output("abort_idle", phase, 0);

        for (int i = 0; i < NWORDS; i++) wds[i] = $urandom;
        build_model();
        clear_logs();
        go = 1'b1; tick(); go = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            apply_stimulus(wds[i], 1'($urandom_range(0, 1)));
            if (i == NTM - 2) check_output("restart_tm_idx", phase, 1);
            if (i == NTM - 1) check_output("restart_tm_end", phase, 2);
        end
        tick(); tick();
        check_output("rnd_phase_wait", phase, 6);
        check_output("rnd_start", start_FIO_TM, 1);
        compare_logs(1'b0);
        finished_TM_FIO = 1'b1; tick(); finished_TM_FIO = 1'b0;
        finish_run(int'($urandom_range(0, 3)), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
